// File: rtl/arbitro_i2s.sv
// arbitro_i2s
// Two-source stereo sample arbiter in front of an I2S serializer.
// Each source hands over {left,right} samples with valid/ready into a
// one-deep buffer. On every serializer `load` strobe one source is picked
// according to `mode`, and its buffered sample is staged on l_data/r_data.
// An empty chosen buffer at load is an underrun: `underrun` pulses for one
// cycle and the saturating `ur_count` increments.
//
// Optional build macro ARBITRO_I2S_HOLD_EN:
//   defined   - on underrun l_data/r_data repeat the last staged sample
//   undefined - on underrun l_data/r_data go to zero (silence)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                1-cycle frame strobe from the serializer
//   mode[1:0]           0=src0, 1=src1, 2=priority src0>src1, 3=mute
//   sN_valid/sN_l/sN_r  source N sample handshake and data
//   sN_ready            source N buffer empty (low during reset)
//   l_data, r_data      staged sample to serializer (registered)
//   grant               source currently staged (registered)
//   underrun            1-cycle pulse, chosen source empty at load
//   ur_count            saturating underrun count
//   ur_clear            synchronous clear of ur_count (wins over increment)

module arbitro_i2s #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic             s0_valid,
    input  logic [WIDTH-1:0] s0_l,
    input  logic [WIDTH-1:0] s0_r,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [WIDTH-1:0] s1_l,
    input  logic [WIDTH-1:0] s1_r,
    output logic             s1_ready,
    output logic [WIDTH-1:0] l_data,
    output logic [WIDTH-1:0] r_data,
    output logic             grant,
    output logic             underrun,
    output logic [CNT_W-1:0] ur_count,
    input  logic             ur_clear
);

    // Per-source views so both buffers share one generate body.
    logic             src_valid [2];
    logic [WIDTH-1:0] src_l     [2];
    logic [WIDTH-1:0] src_r     [2];
    logic             src_ready [2];

    logic [WIDTH-1:0] buf_l_reg [2];
    logic [WIDTH-1:0] buf_r_reg [2];
    logic [1:0]       full_reg;
    logic [1:0]       drain;

    assign src_valid[0] = s0_valid;
    assign src_valid[1] = s1_valid;
    assign src_l[0]     = s0_l;
    assign src_l[1]     = s1_l;
    assign src_r[0]     = s0_r;
    assign src_r[1]     = s1_r;
    assign s0_ready     = src_ready[0];
    assign s1_ready     = src_ready[1];

    // Frame decision, evaluated from the pre-edge flags and mode.
    logic target;
    logic mute;
    logic hit;
    logic ur_event;

    always_comb begin
        target = grant;
        case (mode)
            2'd0:    target = 1'b0;
            2'd1:    target = 1'b1;
            2'd2:    target = full_reg[0] ? 1'b0 : (full_reg[1] ? 1'b1 : grant);
            default: target = grant;
        endcase
        mute     = (mode == 2'd3);
        hit      = full_reg[target];
        ur_event = load & ~mute & ~hit;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // Mute drains every full buffer; otherwise only a hit target drains.
            assign drain[gi] = load & (mute ? full_reg[gi]
                                            : (hit & (target == 1'(gi))));
            assign src_ready[gi] = ~full_reg[gi] & ~reset;

            // A transfer only happens into an empty buffer and a drain only
            // from a full one, so the two never collide on one edge. A
            // sample accepted on a load edge is not seen by that decision.
            always_ff @(posedge clk) begin
                if (reset) begin
                    full_reg[gi]  <= 1'b0;
                    buf_l_reg[gi] <= '0;
                    buf_r_reg[gi] <= '0;
                end else if (src_valid[gi] && src_ready[gi]) begin
                    full_reg[gi]  <= 1'b1;
                    buf_l_reg[gi] <= src_l[gi];
                    buf_r_reg[gi] <= src_r[gi];
                end else if (drain[gi]) begin
                    full_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] l_next;
    logic [WIDTH-1:0] r_next;
    logic             grant_next;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        l_next     = l_data;
        r_next     = r_data;
        grant_next = grant;
        if (load) begin
            if (mute) begin
                l_next = '0;
                r_next = '0;
            end else begin
                grant_next = target;
                if (hit) begin
                    l_next = buf_l_reg[target];
                    r_next = buf_r_reg[target];
                end else begin
`ifdef ARBITRO_I2S_HOLD_EN
                    l_next = l_data;
                    r_next = r_data;
`else
                    l_next = '0;
                    r_next = '0;
`endif
                end
            end
        end

        count_next = ur_count;
        if (ur_clear) begin
            count_next = '0;
        end else if (ur_event && (ur_count != {CNT_W{1'b1}})) begin
            count_next = ur_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_data   <= '0;
            r_data   <= '0;
            grant    <= 1'b0;
            underrun <= 1'b0;
            ur_count <= '0;
        end else begin
            l_data   <= l_next;
            r_data   <= r_next;
            grant    <= grant_next;
            underrun <= ur_event;
            ur_count <= count_next;
        end
    end

endmodule

// File: tb/tb_arbitro_i2s.sv
// Testbench for arbitro_i2s: a cycle-by-cycle vector table followed by
// hand-written sequences for counter saturation (narrow-counter instance)
// and reset with a sample buffered.

module tb_arbitro_i2s;

    localparam int W = 24;

`ifdef ARBITRO_I2S_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, load, ur_clear;
    logic [1:0]   mode;
    logic         s0_valid, s1_valid;
    logic [W-1:0] s0_l, s0_r, s1_l, s1_r;
    logic         s0_ready, s1_ready, grant, underrun;
    logic [W-1:0] l_data, r_data;
    logic [15:0]  ur_count;

    logic         n_s0_ready, n_s1_ready, n_grant, n_underrun;
    logic [W-1:0] n_l_data, n_r_data;
    logic [1:0]   n_ur_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arbitro_i2s #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .load(load), .mode(mode),
        .s0_valid(s0_valid), .s0_l(s0_l), .s0_r(s0_r), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_l(s1_l), .s1_r(s1_r), .s1_ready(s1_ready),
        .l_data(l_data), .r_data(r_data), .grant(grant), .underrun(underrun),
        .ur_count(ur_count), .ur_clear(ur_clear)
    );

    // Narrow-counter instance sharing the same stimulus.
    arbitro_i2s #(.WIDTH(W), .CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .load(load), .mode(mode),
        .s0_valid(s0_valid), .s0_l(s0_l), .s0_r(s0_r), .s0_ready(n_s0_ready),
        .s1_valid(s1_valid), .s1_l(s1_l), .s1_r(s1_r), .s1_ready(n_s1_ready),
        .l_data(n_l_data), .r_data(n_r_data), .grant(n_grant), .underrun(n_underrun),
        .ur_count(n_ur_count), .ur_clear(ur_clear)
    );

    typedef struct {
        logic         rst, ld;
        logic [1:0]   md;
        logic         clr, v0;
        logic [W-1:0] l0, r0;
        logic         v1;
        logic [W-1:0] l1, r1;
        logic [W-1:0] e_l, e_r;
        logic         e_g, e_u;
        logic [15:0]  e_cnt;
        logic         e_rd0, e_rd1;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [W-1:0] h(input logic [W-1:0] prev);
        return HOLD ? prev : '0;
    endfunction

    function automatic vec_t mk(
        input logic rst, ld, input logic [1:0] md, input logic clr,
        input logic v0, input logic [W-1:0] l0, r0,
        input logic v1, input logic [W-1:0] l1, r1,
        input logic [W-1:0] e_l, e_r, input logic e_g, e_u,
        input logic [15:0] e_cnt, input logic e_rd0, e_rd1);
        vec_t v;
        v.rst = rst; v.ld = ld; v.md = md; v.clr = clr;
        v.v0 = v0; v.l0 = l0; v.r0 = r0;
        v.v1 = v1; v.l1 = l1; v.r1 = r1;
        v.e_l = e_l; v.e_r = e_r; v.e_g = e_g; v.e_u = e_u;
        v.e_cnt = e_cnt; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ld, input logic [1:0] md, input logic clr,
                         input logic v0, input logic [W-1:0] l0, r0,
                         input logic v1, input logic [W-1:0] l1, r1);
        reset = rst; load = ld; mode = md; ur_clear = clr;
        s0_valid = v0; s0_l = l0; s0_r = r0;
        s1_valid = v1; s1_l = l1; s1_r = r1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst ld md clr | v0 l0 r0 | v1 l1 r1 | e_l e_r e_g e_u e_cnt rd0 rd1
        vecs[0]  = mk(1,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0,0);
        vecs[1]  = mk(0,0,0,0, 1,24'h000123,24'hFFFF00, 0,0,0, 0,0,0,0,0, 0,1);
        vecs[2]  = mk(0,1,0,0, 0,0,0, 0,0,0, 24'h000123,24'hFFFF00,0,0,0, 1,1);
        vecs[3]  = mk(0,1,0,0, 0,0,0, 0,0,0, h(24'h000123),h(24'hFFFF00),0,1,1, 1,1);
        vecs[4]  = mk(0,1,0,0, 0,0,0, 0,0,0, h(24'h000123),h(24'hFFFF00),0,1,2, 1,1);
        vecs[5]  = mk(0,1,0,0, 0,0,0, 0,0,0, h(24'h000123),h(24'hFFFF00),0,1,3, 1,1);
        vecs[6]  = mk(0,0,0,1, 0,0,0, 0,0,0, h(24'h000123),h(24'hFFFF00),0,0,0, 1,1);
        vecs[7]  = mk(0,0,2,0, 1,24'h10,24'h11, 1,24'h20,24'h21, h(24'h000123),h(24'hFFFF00),0,0,0, 0,0);
        vecs[8]  = mk(0,1,2,0, 0,0,0, 0,0,0, 24'h10,24'h11,0,0,0, 1,0);
        vecs[9]  = mk(0,1,2,0, 0,0,0, 0,0,0, 24'h20,24'h21,1,0,0, 1,1);
        vecs[10] = mk(0,1,2,0, 0,0,0, 0,0,0, h(24'h20),h(24'h21),1,1,1, 1,1);
        vecs[11] = mk(0,0,1,0, 1,24'h30,24'h31, 1,24'h40,24'h41, h(24'h20),h(24'h21),1,0,1, 0,0);
        vecs[12] = mk(0,1,1,0, 0,0,0, 0,0,0, 24'h40,24'h41,1,0,1, 0,1);
        vecs[13] = mk(0,1,1,0, 0,0,0, 0,0,0, h(24'h40),h(24'h41),1,1,2, 0,1);
        vecs[14] = mk(0,0,0,0, 0,0,0, 0,0,0, h(24'h40),h(24'h41),1,0,2, 0,1);
        vecs[15] = mk(0,1,0,0, 0,0,0, 0,0,0, 24'h30,24'h31,0,0,2, 1,1);
        vecs[16] = mk(0,0,3,0, 1,24'h50,24'h51, 1,24'h60,24'h61, 24'h30,24'h31,0,0,2, 0,0);
        vecs[17] = mk(0,1,3,0, 0,0,0, 0,0,0, 0,0,0,0,2, 1,1);
        vecs[18] = mk(0,1,0,1, 0,0,0, 0,0,0, 0,0,0,1,0, 1,1);
        vecs[19] = mk(0,1,0,0, 1,24'h70,24'h71, 0,0,0, 0,0,0,1,1, 0,1);
        vecs[20] = mk(0,1,0,0, 0,0,0, 0,0,0, 24'h70,24'h71,0,0,1, 1,1);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].md, vecs[i].clr,
                  vecs[i].v0, vecs[i].l0, vecs[i].r0,
                  vecs[i].v1, vecs[i].l1, vecs[i].r1);
            $display("vec %0d: l=%h r=%h g=%0d u=%0d cnt=%0d rdy=%0d%0d",
                     i, l_data, r_data, grant, underrun, ur_count, s0_ready, s1_ready);
            chk($sformatf("v%0d l_data", i), 32'(l_data), 32'(vecs[i].e_l));
            chk($sformatf("v%0d r_data", i), 32'(r_data), 32'(vecs[i].e_r));
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_g));
            chk($sformatf("v%0d underrun", i), 32'(underrun), 32'(vecs[i].e_u));
            chk($sformatf("v%0d ur_count", i), 32'(ur_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d s0_ready", i), 32'(s0_ready), 32'(vecs[i].e_rd0));
            chk($sformatf("v%0d s1_ready", i), 32'(s1_ready), 32'(vecs[i].e_rd1));
        end

        // Saturation: clear, then five underruns in mode 0.
        drive(0,0,0,1, 0,0,0, 0,0,0);
        $display("sat clear: cnt=%0d ncnt=%0d", ur_count, n_ur_count);
        chk("sat clear cnt", 32'(ur_count), 32'd0);
        chk("sat clear ncnt", 32'(n_ur_count), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(0,1,0,0, 0,0,0, 0,0,0);
            $display("sat load %0d: u=%0d cnt=%0d ncnt=%0d", k, underrun, ur_count, n_ur_count);
            chk($sformatf("sat%0d underrun", k), 32'(n_underrun), 32'd1);
            chk($sformatf("sat%0d cnt", k), 32'(ur_count), 32'(k));
            chk($sformatf("sat%0d ncnt", k), 32'(n_ur_count), (k > 3) ? 32'd3 : 32'(k));
        end

        // Reset with a sample buffered: stage s1 in mode 1, buffer another,
        // then reset between loads.
        drive(0,0,1,0, 0,0,0, 1,24'h80,24'h81);
        drive(0,1,1,0, 0,0,0, 0,0,0);
        $display("pre-reset stage: l=%h r=%h g=%0d", l_data, r_data, grant);
        chk("pre-reset l_data", 32'(l_data), 32'h80);
        chk("pre-reset grant", 32'(grant), 32'd1);
        drive(0,0,1,0, 0,0,0, 1,24'h90,24'h91);
        chk("buffered s1_ready", 32'(s1_ready), 32'd0);
        drive(1,0,1,0, 0,0,0, 0,0,0);
        $display("reset: l=%h r=%h g=%0d u=%0d cnt=%0d rdy=%0d%0d",
                 l_data, r_data, grant, underrun, ur_count, s0_ready, s1_ready);
        chk("reset l_data", 32'(l_data), 32'd0);
        chk("reset r_data", 32'(r_data), 32'd0);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset ur_count", 32'(ur_count), 32'd0);
        chk("reset ncount", 32'(n_ur_count), 32'd0);
        chk("reset s1_ready", 32'(s1_ready), 32'd0);
        chk("reset s0_ready", 32'(s0_ready), 32'd0);
        drive(0,0,1,0, 0,0,0, 0,0,0);
        chk("post-reset s1_ready", 32'(s1_ready), 32'd1);
        drive(0,1,1,0, 0,0,0, 0,0,0);
        $display("post-reset load: l=%h g=%0d u=%0d cnt=%0d", l_data, grant, underrun, ur_count);
        chk("post-reset underrun", 32'(underrun), 32'd1);
        chk("post-reset cnt", 32'(ur_count), 32'd1);
        chk("post-reset l_data", 32'(l_data), 32'd0);
        chk("post-reset grant", 32'(grant), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
